// File: rtl/branch_pred_ctrl.sv
// ============================================================================
// Module      : branch_pred_ctrl
// Description : Next-PC selection, prediction tracking through IF/ID and ID/EX,
//               EX-stage misprediction detection, registered BTB update and
//               saturating branch / misprediction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pred_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic             pred_take,
    input  logic [31:0]      pred_pc,
    input  logic             stall,
    input  logic             ex_is_br,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    output logic [31:0]      npc,
    output logic             flush,
    output logic             btb_wr_en,
    output logic [31:0]      btb_wr_pc,
    output logic             btb_wr_taken,
    output logic [31:0]      btb_wr_target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [31:0]      c_PC_STEP = 32'd4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Per-stage prediction records
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_id_pred_take;
    logic [31:0] r_id_pred_pc;
    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic        r_ex_pred_take;
    logic [31:0] r_ex_pred_pc;

    logic             r_btb_wr_en;
    logic [31:0]      r_btb_wr_pc;
    logic             r_btb_wr_taken;
    logic [31:0]      r_btb_wr_target;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic        w_br;
    logic        w_fh;
    logic        w_mismatch;
    logic        w_mispred;
    logic [31:0] w_redirect;
    logic [31:0] w_seq_pc;

    always_comb begin
        w_br       = r_ex_valid & ex_is_br;
        w_fh       = r_ex_valid & ~ex_is_br & r_ex_pred_take;
        w_mismatch = (ex_br_taken != r_ex_pred_take) ||
                     (ex_br_taken && r_ex_pred_take && (ex_br_target != r_ex_pred_pc));
        w_mispred  = (w_br & w_mismatch) | w_fh;
        w_redirect = (w_br & ex_br_taken) ? ex_br_target : (r_ex_pc + c_PC_STEP);
        w_seq_pc   = pred_take ? pred_pc : (if_pc + c_PC_STEP);
    end

    assign npc   = w_mispred ? w_redirect : w_seq_pc;
    assign flush = w_mispred;

    // Flush outranks stall; a stall only bubbles EX and freezes ID
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid     <= 1'b0;
            r_id_pc        <= 32'd0;
            r_id_pred_take <= 1'b0;
            r_id_pred_pc   <= 32'd0;
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= 32'd0;
            r_ex_pred_take <= 1'b0;
            r_ex_pred_pc   <= 32'd0;
        end else if (w_mispred) begin
            r_id_valid <= 1'b0;
            r_ex_valid <= 1'b0;
        end else if (stall) begin
            r_ex_valid <= 1'b0;
        end else begin
            r_id_valid     <= 1'b1;
            r_id_pc        <= if_pc;
            r_id_pred_take <= pred_take;
            r_id_pred_pc   <= pred_pc;
            r_ex_valid     <= r_id_valid;
            r_ex_pc        <= r_id_pc;
            r_ex_pred_take <= r_id_pred_take;
            r_ex_pred_pc   <= r_id_pred_pc;
        end
    end

    // A correct not-taken prediction writes nothing; taken refreshes; false hit invalidates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_wr_en     <= 1'b0;
            r_btb_wr_pc     <= 32'd0;
            r_btb_wr_taken  <= 1'b0;
            r_btb_wr_target <= 32'd0;
        end else begin
            r_btb_wr_en     <= (w_br & (w_mispred | ex_br_taken)) | w_fh;
            r_btb_wr_pc     <= r_ex_pc;
            r_btb_wr_taken  <= w_br & ex_br_taken;
            r_btb_wr_target <= ex_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_br && (r_br_cnt != c_CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + c_CNT_ONE;
            end
            if (w_mispred && (r_mispred_cnt != c_CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
            end
        end
    end

    assign btb_wr_en     = r_btb_wr_en;
    assign btb_wr_pc     = r_btb_wr_pc;
    assign btb_wr_taken  = r_btb_wr_taken;
    assign btb_wr_target = r_btb_wr_target;
    assign br_cnt        = r_br_cnt;
    assign mispred_cnt   = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Directed and randomized checking of branch_pred_ctrl against an
//               in-bench instruction-level reference model (wide and 2-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pred_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_take;
    logic [31:0] pred_pc;
    logic        stall;
    logic        ex_is_br;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;

    logic [31:0] npc, npc_s;
    logic        flush, flush_s;
    logic        btb_wr_en, btb_wr_en_s;
    logic [31:0] btb_wr_pc, btb_wr_pc_s;
    logic        btb_wr_taken, btb_wr_taken_s;
    logic [31:0] btb_wr_target, btb_wr_target_s;
    logic [31:0] br_cnt, mispred_cnt;
    logic [1:0]  br_cnt_s, mispred_cnt_s;

    branch_pred_ctrl dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_take(pred_take), .pred_pc(pred_pc),
        .stall(stall), .ex_is_br(ex_is_br), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .npc(npc), .flush(flush), .btb_wr_en(btb_wr_en),
        .btb_wr_pc(btb_wr_pc), .btb_wr_taken(btb_wr_taken), .btb_wr_target(btb_wr_target),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_pred_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_take(pred_take), .pred_pc(pred_pc),
        .stall(stall), .ex_is_br(ex_is_br), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .npc(npc_s), .flush(flush_s), .btb_wr_en(btb_wr_en_s),
        .btb_wr_pc(btb_wr_pc_s), .btb_wr_taken(btb_wr_taken_s),
        .btb_wr_target(btb_wr_target_s), .br_cnt(br_cnt_s), .mispred_cnt(mispred_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] pp;
    } instr_t;

    // Index 0: decoding instruction, index 1: executing instruction
    instr_t      inflight [2];
    longint      n_br, n_mis;
    bit          m_wr_en, m_wr_taken;
    logic [31:0] m_wr_pc, m_wr_target;
    bit          chk_en;
    int          vec_cnt, err_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint n, input longint maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic step(input bit r, input logic [31:0] ipc, input bit pt, input logic [31:0] pp,
                        input bit st, input bit isbr, input bit tk, input logic [31:0] tgt);
        bit          br, fh, mis;
        logic [31:0] exp_npc, seq;
        rst = r; if_pc = ipc; pred_take = pt; pred_pc = pp;
        stall = st; ex_is_br = isbr; ex_br_taken = tk; ex_br_target = tgt;
        #1;
        br  = inflight[1].valid && isbr;
        fh  = inflight[1].valid && !isbr && inflight[1].pt;
        mis = fh || (br && ((tk != inflight[1].pt) ||
                            (tk && inflight[1].pt && tgt != inflight[1].pp)));
        seq = inflight[1].pc + 32'd4;
        if (mis) exp_npc = (br && tk) ? tgt : seq;
        else     exp_npc = pt ? pp : ipc + 32'd4;
        if (chk_en) begin
            check_val("npc", npc, exp_npc);
            check_val("flush", flush, mis);
            check_val("npc_sat", npc_s, exp_npc);
            check_val("btb_wr_en", btb_wr_en, m_wr_en);
            check_val("btb_wr_taken", btb_wr_taken, m_wr_taken);
            if (m_wr_en) begin
                check_val("btb_wr_pc", btb_wr_pc, m_wr_pc);
                check_val("btb_wr_target", btb_wr_target, m_wr_target);
            end
            check_val("br_cnt", br_cnt, sat(n_br, 64'hFFFF_FFFF));
            check_val("mispred_cnt", mispred_cnt, sat(n_mis, 64'hFFFF_FFFF));
            check_val("br_cnt_sat", br_cnt_s, sat(n_br, 3));
            check_val("mispred_cnt_sat", mispred_cnt_s, sat(n_mis, 3));
        end
        @(posedge clk);
        if (r) begin
            inflight[0].valid = 0; inflight[1].valid = 0;
            inflight[0].pc = '0; inflight[1].pc = '0;
            inflight[0].pt = 0; inflight[1].pt = 0;
            inflight[0].pp = '0; inflight[1].pp = '0;
            m_wr_en = 0; m_wr_taken = 0; m_wr_pc = '0; m_wr_target = '0;
            n_br = 0; n_mis = 0; chk_en = 1;
        end else begin
            m_wr_en = (br && (mis || tk)) || fh;
            m_wr_taken = br && tk;
            m_wr_pc = inflight[1].pc;
            m_wr_target = tgt;
            if (br)  n_br++;
            if (mis) n_mis++;
            if (mis) begin
                inflight[0].valid = 0; inflight[1].valid = 0;
            end else if (st) begin
                inflight[1].valid = 0;
            end else begin
                inflight[1] = inflight[0];
                inflight[0] = '{1, ipc, pt, pp};
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] ipc, pp, tgt;
        bit          pt, st, isbr, tk, r;
        vec_cnt = 0; err_cnt = 0; chk_en = 0;
        n_br = 0; n_mis = 0;
        inflight[0] = '{0, '0, 0, '0}; inflight[1] = '{0, '0, 0, '0};
        m_wr_en = 0; m_wr_taken = 0; m_wr_pc = '0; m_wr_target = '0;

        step(1, 32'h100, 0, 0, 0, 0, 0, 0);
        step(1, 32'h100, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 32'h100, 0, 0, 0, 0, 0, 0);
        // cold taken branch at 0x200
        step(0, 32'h200, 0, 0, 0, 0, 0, 0);
        step(0, 32'h204, 0, 0, 0, 0, 0, 0);
        step(0, 32'h208, 0, 0, 0, 1, 1, 32'h400);
        step(0, 32'h400, 0, 0, 0, 0, 0, 0);
        // correct taken prediction, then wrong target
        step(0, 32'h200, 1, 32'h400, 0, 0, 0, 0);
        step(0, 32'h400, 0, 0, 0, 0, 0, 0);
        step(0, 32'h404, 0, 0, 0, 1, 1, 32'h400);
        step(0, 32'h200, 1, 32'h400, 0, 0, 0, 0);
        step(0, 32'h400, 0, 0, 0, 0, 0, 0);
        step(0, 32'h404, 0, 0, 0, 1, 1, 32'h480);
        // false hit at 0x300
        step(0, 32'h300, 1, 32'h500, 0, 0, 0, 0);
        step(0, 32'h500, 0, 0, 0, 0, 0, 0);
        step(0, 32'h504, 0, 0, 0, 0, 0, 0);
        // branch held in ID by a two-cycle stall
        step(0, 32'h600, 0, 0, 0, 0, 0, 0);
        step(0, 32'h604, 0, 0, 1, 0, 0, 0);
        step(0, 32'h604, 0, 0, 1, 1, 1, 32'h700);
        step(0, 32'h604, 0, 0, 0, 1, 1, 32'h700);
        step(0, 32'h608, 0, 0, 0, 1, 1, 32'h700);
        // PC wrap
        step(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            ipc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            pt   = ($urandom_range(0, 2) == 0);
            pp   = $urandom & 32'hFFFF_FFFC;
            st   = ($urandom_range(0, 4) == 0);
            isbr = ($urandom_range(0, 1) == 1);
            tk   = ($urandom_range(0, 1) == 1);
            tgt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                tk  = inflight[1].pt;
                tgt = inflight[1].pp;
                isbr = isbr | inflight[1].pt;
            end
            step(r, ipc, pt, pp, st, isbr, tk, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
